// File: rtl/missile_pkg.sv
// Shared types and default constants for the player missile controller.
package missile_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_FLYING   = 2'd1,
        ST_COOLDOWN = 2'd2
    } missile_state_t;

    localparam int          DEF_MISSILE_W       = 4;
    localparam int          DEF_MISSILE_H       = 12;
    localparam int          DEF_SPEED           = 8;
    localparam int          DEF_COOLDOWN_FRAMES = 10;
    localparam int          DEF_PLAYER_W        = 64;
    localparam logic [11:0] DEF_MISSILE_COLOR   = 12'hF00;
    localparam logic [11:0] BLANK_COLOR         = 12'h000;

    // Launch row sits just above the player; clamp at the top of the screen.
    function automatic logic [10:0] launch_y(input logic [10:0] ypos, input int height);
        if (ypos >= 11'(height))
            return ypos - 11'(height);
        else
            return 11'd0;
    endfunction

endpackage

// File: rtl/missile_ctl_frame_tick.sv
// One-cycle frame tick on the rising edge of vertical blanking.
module frame_tick (
    input  logic pclk,
    input  logic rst_n,
    input  logic vblnk,
    output logic tick
);

    logic vblnk_prev_reg;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            vblnk_prev_reg <= 1'b0;
        else
            vblnk_prev_reg <= vblnk;
    end

    assign tick = vblnk & ~vblnk_prev_reg;

endmodule

// File: rtl/missile_ctl.sv
// Player missile: launch/fly/cooldown FSM plus a one-cycle video overlay stage.
// Build option: define MISSILE_AUTOFIRE_EN for level-sensitive continuous fire.
module missile_ctl
    import missile_pkg::*;
#(
    parameter int          MISSILE_W       = DEF_MISSILE_W,
    parameter int          MISSILE_H       = DEF_MISSILE_H,
    parameter int          SPEED           = DEF_SPEED,
    parameter int          COOLDOWN_FRAMES = DEF_COOLDOWN_FRAMES,
    parameter int          PLAYER_W        = DEF_PLAYER_W,
    parameter logic [11:0] MISSILE_COLOR   = DEF_MISSILE_COLOR
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        fire,
    input  logic [10:0] xpos_player,
    input  logic [10:0] ypos_player,
    input  logic        hit,
    input  logic [10:0] hcount_in,
    input  logic [10:0] vcount_in,
    input  logic        hsync_in,
    input  logic        vsync_in,
    input  logic        hblnk_in,
    input  logic        vblnk_in,
    input  logic [11:0] rgb_in,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        vsync_out,
    output logic        hblnk_out,
    output logic        vblnk_out,
    output logic [11:0] rgb_out,
    output logic [10:0] xpos_missile,
    output logic [10:0] ypos_missile,
    output logic        on_missle
);

    localparam logic [10:0] X_OFFSET = 11'((PLAYER_W - MISSILE_W) / 2);
    localparam logic [10:0] SPEED_V  = 11'(SPEED);
    localparam logic [7:0]  CD_LAST  = 8'(COOLDOWN_FRAMES - 1);
    localparam logic [11:0] W_EXT    = 12'(MISSILE_W);
    localparam logic [11:0] H_EXT    = 12'(MISSILE_H);

    logic           frame_tick_pulse;
    logic           launch;

    missile_state_t state_reg, state_next;
    logic [7:0]     cnt_reg, cnt_next;
    logic [10:0]    x_reg, x_next;
    logic [10:0]    y_reg, y_next;
    logic           on_reg, on_next;

    logic [10:0]    hcount_reg, vcount_reg;
    logic           hsync_reg, vsync_reg, hblnk_reg, vblnk_reg;
    logic [11:0]    rgb_reg, rgb_next;

    frame_tick u_frame_tick (
        .pclk  (pclk),
        .rst_n (rst_n),
        .vblnk (vblnk_in),
        .tick  (frame_tick_pulse)
    );

`ifdef MISSILE_AUTOFIRE_EN
    // Armed once fire has been seen low after reset, so a button held
    // through reset cannot launch; afterwards fire is purely level-sensitive.
    logic fire_armed_reg;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            fire_armed_reg <= 1'b0;
        else
            fire_armed_reg <= fire_armed_reg | ~fire;
    end

    assign launch = fire & fire_armed_reg;
`else
    // Holds "fire was low last cycle"; resetting it to 0 blocks a launch
    // from a level that was already high when reset released.
    logic fire_low_reg;

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n)
            fire_low_reg <= 1'b0;
        else
            fire_low_reg <= ~fire;
    end

    assign launch = fire & fire_low_reg;
`endif

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            cnt_reg   <= 8'd0;
            x_reg     <= 11'd0;
            y_reg     <= 11'd0;
            on_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            on_reg    <= on_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        on_next    = on_reg;
        case (state_reg)
            ST_IDLE: begin
                if (launch) begin
                    x_next     = xpos_player + X_OFFSET;
                    y_next     = launch_y(ypos_player, MISSILE_H);
                    on_next    = 1'b1;
                    state_next = ST_FLYING;
                end
            end
            ST_FLYING: begin
                // A collision outranks movement in the same cycle.
                if (hit) begin
                    on_next    = 1'b0;
                    cnt_next   = 8'd0;
                    state_next = ST_COOLDOWN;
                end else if (frame_tick_pulse) begin
                    if (y_reg >= SPEED_V) begin
                        y_next = y_reg - SPEED_V;
                    end else begin
                        on_next    = 1'b0;
                        cnt_next   = 8'd0;
                        state_next = ST_COOLDOWN;
                    end
                end
            end
            ST_COOLDOWN: begin
                if (frame_tick_pulse) begin
                    if (cnt_reg == CD_LAST) begin
                        cnt_next   = 8'd0;
                        state_next = ST_IDLE;
                    end else begin
                        cnt_next = cnt_reg + 8'd1;
                    end
                end
            end
            default: begin
                state_next = ST_IDLE;
                on_next    = 1'b0;
            end
        endcase
    end

    // Region bounds are widened to 12 bits so x+W and y+H cannot wrap.
    logic [11:0] x_end, y_end;
    logic        in_x, in_y;

    always_comb begin
        x_end    = {1'b0, x_reg} + W_EXT;
        y_end    = {1'b0, y_reg} + H_EXT;
        in_x     = (hcount_in >= x_reg) && ({1'b0, hcount_in} < x_end);
        in_y     = (vcount_in >= y_reg) && ({1'b0, vcount_in} < y_end);
        rgb_next = rgb_in;
        if (hblnk_in || vblnk_in)
            rgb_next = BLANK_COLOR;
        else if (on_reg && in_x && in_y)
            rgb_next = MISSILE_COLOR;
    end

    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_reg <= 11'd0;
            vcount_reg <= 11'd0;
            hsync_reg  <= 1'b0;
            vsync_reg  <= 1'b0;
            hblnk_reg  <= 1'b0;
            vblnk_reg  <= 1'b0;
            rgb_reg    <= 12'd0;
        end else begin
            hcount_reg <= hcount_in;
            vcount_reg <= vcount_in;
            hsync_reg  <= hsync_in;
            vsync_reg  <= vsync_in;
            hblnk_reg  <= hblnk_in;
            vblnk_reg  <= vblnk_in;
            rgb_reg    <= rgb_next;
        end
    end

    assign hcount_out   = hcount_reg;
    assign vcount_out   = vcount_reg;
    assign hsync_out    = hsync_reg;
    assign vsync_out    = vsync_reg;
    assign hblnk_out    = hblnk_reg;
    assign vblnk_out    = vblnk_reg;
    assign rgb_out      = rgb_reg;
    assign xpos_missile = x_reg;
    assign ypos_missile = y_reg;
    assign on_missle    = on_reg;

endmodule

// File: tb/tb_missile_ctl.sv
// Self-checking bench for missile_ctl: directed scenarios plus random traffic
// checked every cycle against a behavioural model of the missile rules.
module tb_missile_ctl;

    localparam int          P_W   = 4;
    localparam int          P_H   = 12;
    localparam int          P_SPD = 8;
    localparam int          P_CD  = 10;
    localparam int          P_PW  = 64;
    localparam logic [11:0] P_COL = 12'hF00;
    localparam int          FRAME = 16;

    logic        pclk;
    logic        rst_n;
    logic        fire;
    logic [10:0] xpos_player, ypos_player;
    logic        hit;
    logic [10:0] hcount_in, vcount_in;
    logic        hsync_in, vsync_in, hblnk_in, vblnk_in;
    logic [11:0] rgb_in;
    logic [10:0] hcount_out, vcount_out;
    logic        hsync_out, vsync_out, hblnk_out, vblnk_out;
    logic [11:0] rgb_out;
    logic [10:0] xpos_missile, ypos_missile;
    logic        on_missle;

    missile_ctl dut (
        .pclk         (pclk),
        .rst_n        (rst_n),
        .fire         (fire),
        .xpos_player  (xpos_player),
        .ypos_player  (ypos_player),
        .hit          (hit),
        .hcount_in    (hcount_in),
        .vcount_in    (vcount_in),
        .hsync_in     (hsync_in),
        .vsync_in     (vsync_in),
        .hblnk_in     (hblnk_in),
        .vblnk_in     (vblnk_in),
        .rgb_in       (rgb_in),
        .hcount_out   (hcount_out),
        .vcount_out   (vcount_out),
        .hsync_out    (hsync_out),
        .vsync_out    (vsync_out),
        .hblnk_out    (hblnk_out),
        .vblnk_out    (vblnk_out),
        .rgb_out      (rgb_out),
        .xpos_missile (xpos_missile),
        .ypos_missile (ypos_missile),
        .on_missle    (on_missle)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    int n_vec = 0;
    int n_err = 0;

    // Model: a missile is either in the air (m_on), or waiting out
    // m_cool_left more frame ticks, or ready.
    bit m_on;
    int mx, my;
    int m_cool_left;
    bit m_vb_prev, m_fire_low, m_armed;
    int e_hc, e_vc, e_rgb;
    bit e_hs, e_vs, e_hb, e_vb;

    int fcnt = 0;
    bit auto_vb = 1'b1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_on = 0; mx = 0; my = 0; m_cool_left = 0;
        m_vb_prev = 0; m_fire_low = 0; m_armed = 0;
        e_hc = 0; e_vc = 0; e_rgb = 0;
        e_hs = 0; e_vs = 0; e_hb = 0; e_vb = 0;
    endfunction

    function automatic bit tick_pending();
        return rst_n && vblnk_in && !m_vb_prev;
    endfunction

    function automatic bit model_ready();
        return !m_on && (m_cool_left == 0);
    endfunction

    // Advance the model across one rising edge using the inputs now applied.
    function automatic void model_edge();
        bit tick, launch;
        int hc, vc;
        if (!rst_n) begin
            model_reset();
            return;
        end
        hc = int'(hcount_in);
        vc = int'(vcount_in);
        e_hc = hc; e_vc = vc;
        e_hs = hsync_in; e_vs = vsync_in; e_hb = hblnk_in; e_vb = vblnk_in;
        if (hblnk_in || vblnk_in)
            e_rgb = 0;
        else if (m_on && hc >= mx && hc < mx + P_W && vc >= my && vc < my + P_H)
            e_rgb = int'(P_COL);
        else
            e_rgb = int'(rgb_in);
        tick = vblnk_in && !m_vb_prev;
`ifdef MISSILE_AUTOFIRE_EN
        launch = fire && m_armed;
`else
        launch = fire && m_fire_low;
`endif
        if (m_on) begin
            if (hit) begin
                m_on = 0; m_cool_left = P_CD;
            end else if (tick) begin
                if (my >= P_SPD) my = my - P_SPD;
                else begin m_on = 0; m_cool_left = P_CD; end
            end
        end else if (m_cool_left > 0) begin
            if (tick) m_cool_left--;
        end else if (launch) begin
            mx = (int'(xpos_player) + (P_PW - P_W) / 2) % 2048;
            my = (int'(ypos_player) >= P_H) ? int'(ypos_player) - P_H : 0;
            m_on = 1;
        end
        m_vb_prev  = vblnk_in;
        m_fire_low = !fire;
        m_armed    = m_armed || !fire;
    endfunction

    task automatic check_all();
        chk("hcount_out",   hcount_out,   e_hc);
        chk("vcount_out",   vcount_out,   e_vc);
        chk("hsync_out",    hsync_out,    e_hs);
        chk("vsync_out",    vsync_out,    e_vs);
        chk("hblnk_out",    hblnk_out,    e_hb);
        chk("vblnk_out",    vblnk_out,    e_vb);
        chk("rgb_out",      rgb_out,      e_rgb);
        chk("on_missle",    on_missle,    m_on);
        chk("xpos_missile", xpos_missile, mx);
        chk("ypos_missile", ypos_missile, my);
    endtask

    task automatic step();
        model_edge();
        @(posedge pclk);
        #1;
        check_all();
        fcnt++;
        if (auto_vb) vblnk_in = (fcnt % FRAME) >= FRAME - 4;
    endtask

    // Point the beam at or just around the current missile.
    task automatic aim_near();
        int h, v;
        h = mx + int'($urandom_range(0, P_W + 3)) - 2;
        v = my + int'($urandom_range(0, P_H + 3)) - 2;
        hcount_in = 11'((h < 0) ? 0 : (h > 2047 ? 2047 : h));
        vcount_in = 11'((v < 0) ? 0 : (v > 2047 ? 2047 : v));
        rgb_in    = 12'($urandom);
        hsync_in  = 1'($urandom);
        vsync_in  = 1'($urandom);
    endtask

    task automatic wait_ready(input string tag);
        int i;
        for (i = 0; i < 4000 && !model_ready(); i++) begin
            aim_near();
            step();
        end
        n_vec++;
        if (!model_ready()) begin
            n_err++;
            $error("FAIL %s wait timed out observed=busy expected=ready", tag);
        end
    endtask

    initial begin
        logic [11:0] saved_rgb;
        logic [10:0] saved_y;
        bit          found;

        // Reset with fire already held high.
        rst_n = 0; fire = 1; hit = 0;
        xpos_player = 0; ypos_player = 0;
        hcount_in = 0; vcount_in = 0; rgb_in = 0;
        hsync_in = 0; vsync_in = 0; hblnk_in = 0; vblnk_in = 0;
        model_reset();
        repeat (3) step();

        rst_n = 1;
        repeat (6) begin aim_near(); step(); end
        chk("no_launch_after_reset", on_missle, 1'b0);

        // Launch from (300,500).
        xpos_player = 11'd300; ypos_player = 11'd500;
        fire = 0; step();
        fire = 1; step();
        chk("launch_on",   on_missle,    1'b1);
        chk("launch_xpos", xpos_missile, 11'd330);
        chk("launch_ypos", ypos_missile, 11'd488);
        fire = 0;

        // Overlay corner cases with blanking controlled by hand.
        auto_vb = 0; vblnk_in = 0; hblnk_in = 0;
        hcount_in = 11'd331; vcount_in = 11'd490; rgb_in = 12'h5A5;
        step();
        chk("pix_inside", rgb_out, P_COL);
        hcount_in = 11'd334; rgb_in = 12'h3C7; saved_rgb = rgb_in;
        step();
        chk("pix_right_edge", rgb_out, saved_rgb);
        hcount_in = 11'd331; hblnk_in = 1;
        step();
        chk("pix_hblank", rgb_out, 12'h000);
        hblnk_in = 0; auto_vb = 1;

        // Full flight to the top, fire held high through the cooldown.
        for (int i = 0; i < 3000 && m_on; i++) begin
            aim_near(); step();
        end
        chk("flight_top_y",   ypos_missile, 11'd0);
        chk("flight_top_off", on_missle,    1'b0);
        fire = 1;
        wait_ready("cooldown_end");
        repeat (20) begin aim_near(); step(); end
`ifndef MISSILE_AUTOFIRE_EN
        chk("held_fire_no_relaunch", on_missle, 1'b0);
`endif

        // Fresh edge relaunches; then collide on a frame tick.
        wait_ready("relaunch_ready");
        fire = 0; step();
        fire = 1; xpos_player = 11'd100; ypos_player = 11'd400; step();
        chk("relaunch_on", on_missle, 1'b1);
        fire = 0;
        repeat (2 * FRAME) begin aim_near(); step(); end
        found = 0;
        for (int i = 0; i < 2 * FRAME && !found; i++) begin
            if (tick_pending()) found = 1;
            else begin aim_near(); step(); end
        end
        n_vec++;
        if (!found) begin
            n_err++;
            $error("FAIL tick_search observed=none expected=tick");
        end
        saved_y = ypos_missile;
        hit = 1; aim_near(); step();
        hit = 0;
        chk("hit_tick_off",  on_missle,    1'b0);
        chk("hit_tick_ypos", ypos_missile, saved_y);
        wait_ready("after_hit");

        // Random traffic.
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 3) == 0) fire = 1'($urandom);
            hit = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 31) == 0) begin
                case ($urandom_range(0, 2))
                    0: xpos_player = 11'($urandom_range(2010, 2047));
                    default: xpos_player = 11'($urandom_range(0, 1500));
                endcase
                ypos_player = ($urandom_range(0, 3) == 0) ? 11'($urandom_range(0, 20))
                                                          : 11'($urandom_range(0, 799));
            end
            hblnk_in = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 1) == 0) aim_near();
            else begin
                hcount_in = 11'($urandom); vcount_in = 11'($urandom); rgb_in = 12'($urandom);
            end
            step();
        end
        hblnk_in = 0; hit = 0;

        // Reset mid-flight with fire held; outputs drop without a clock edge.
        wait_ready("pre_reset_ready");
        fire = 0; step();
        fire = 1; xpos_player = 11'd600; ypos_player = 11'd300; step();
        repeat (5) begin aim_near(); step(); end
        #3;
        rst_n = 0;
        #1;
        model_reset();
        check_all();
        repeat (2) step();
        rst_n = 1;
        repeat (20) begin aim_near(); step(); end
        chk("no_launch_after_midflight_reset", on_missle, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/missile_ctl.md
MISSILE_CTL -- requirements
Module: missile_ctl

Interface
REQ-001 SHALL have parameter MISSILE_W, default 4, missile width in pixels.
REQ-002 SHALL have parameter MISSILE_H, default 12, missile height in pixels.
REQ-003 SHALL have parameter SPEED, default 8, pixels moved upward per frame.
REQ-004 SHALL have parameter COOLDOWN_FRAMES, default 10, frames before re-arm; legal range 1..255.
REQ-005 SHALL have parameter PLAYER_W, default 64, player sprite width used for centring.
REQ-006 SHALL have parameter MISSILE_COLOR, default 12'hF00, missile pixel colour.
REQ-007 SHALL have ports: pclk  in  1  pixel clock, the single clock; all logic on its rising edge.
REQ-008 SHALL have ports: rst_n  in  1  asynchronous active-low reset.
REQ-009 SHALL have ports: fire  in  1  fire button level, already synchronised to pclk.
REQ-010 SHALL have ports: xpos_player, ypos_player  in  11 each  player sprite top-left.
REQ-011 SHALL have ports: hit  in  1  single-cycle collision pulse from the enemy chain.
REQ-012 SHALL have ports: hcount_in, vcount_in  in  11 each; hsync_in, vsync_in, hblnk_in, vblnk_in  in  1 each; rgb_in  in  12.
REQ-013 SHALL have ports: hcount_out, vcount_out  out  11 each; hsync_out, vsync_out, hblnk_out, vblnk_out  out  1 each; rgb_out  out  12.
REQ-014 SHALL have ports: xpos_missile, ypos_missile  out  11 each; on_missle  out  1  missile in flight.

Function
REQ-015 SHALL register all timing outputs with exactly 1 pclk of latency relative to the inputs.
REQ-016 SHALL generate an internal frame tick on the rising edge of vblnk_in, one cycle wide.
REQ-017 SHALL implement the states IDLE, FLYING and COOLDOWN.
REQ-018 SHALL, in IDLE on a rising edge of fire, latch xpos_missile = xpos_player + (PLAYER_W-MISSILE_W)/2 and ypos_missile = ypos_player - MISSILE_H (saturating at 0), enter FLYING, and assert on_missle on the next cycle.
REQ-019 SHALL, in FLYING on a frame tick, subtract SPEED from ypos_missile when ypos_missile >= SPEED; otherwise clear on_missle and enter COOLDOWN without wrapping.
REQ-020 SHALL, in FLYING with hit=1, clear on_missle and enter COOLDOWN on the next cycle; when hit and a frame tick coincide, hit takes priority.
REQ-021 SHALL ignore hit in IDLE and COOLDOWN, and ignore fire in FLYING and COOLDOWN.
REQ-022 SHALL, in COOLDOWN, count frame ticks with an 8-bit counter and return to IDLE on the COOLDOWN_FRAMES-th tick.
REQ-023 SHALL hold xpos_missile and ypos_missile at their last values outside FLYING.
REQ-024 SHALL drive rgb_out = MISSILE_COLOR when on_missle=1, hcount_in is in [x, x+MISSILE_W) and vcount_in is in [y, y+MISSILE_H); otherwise rgb_out = rgb_in.
REQ-025 SHALL drive rgb_out = 12'h000 whenever hblnk_in or vblnk_in is 1.
REQ-026 SHALL use 12-bit intermediate arithmetic for all region bounds, so that x+W and y+H do not overflow.

Reset
REQ-027 SHALL, on rst_n=0, immediately force state IDLE, the cooldown counter, xpos_missile, ypos_missile, on_missle, rgb_out, all timing outputs and the edge-detect registers to 0.
REQ-028 SHALL abort a flight when reset is asserted mid-flight, with no residual missile pixels after release.
REQ-029 SHALL not launch on a fire level that was already high when rst_n deasserts; a fresh rising edge is required.

Configuration
REQ-030 SHALL, with MISSILE_AUTOFIRE_EN defined, launch from IDLE whenever fire=1, level-sensitive, giving continuous fire while the button is held.
REQ-031 SHALL, without MISSILE_AUTOFIRE_EN, launch only on a 0->1 transition of fire.

Structure
REQ-032 SHALL place the state enum and the default constants (size, speed, colour, cooldown) in the shared package missile_pkg.
REQ-033 SHALL instantiate one sub-module, frame_tick, which detects the vblnk_in rising edge and outputs the tick.

Verification
REQ-034 SHALL cover: xpos_player=300, ypos_player=500, fire edge -> next cycle on_missle=1, xpos_missile=330, ypos_missile=488.
REQ-035 SHALL cover: flight from ypos 488 with no hit -> ypos 480, 472, ... 8, 0 on successive ticks; the next tick clears on_missle; IDLE after 10 further ticks.
REQ-036 SHALL cover: hit pulse in the same cycle as a frame tick during FLYING -> on_missle=0 next cycle, ypos unchanged, COOLDOWN entered.
REQ-037 SHALL cover: missile at (330,488), pixel (331,490) -> rgb_out=12'hF00 one cycle later; pixel (334,490) -> rgb_in passed through; any pixel with hblnk_in=1 -> 12'h000.
REQ-038 SHALL cover: fire held high across the end of COOLDOWN -> no relaunch without MISSILE_AUTOFIRE_EN, relaunch in the first IDLE cycle with it.
REQ-039 SHALL cover: rst_n pulsed low mid-flight -> all outputs 0 within the same cycle; fire held high through reset -> no launch after release.
